seq_game_core: RTL

SEQ_GAME_CORE -- requirements
Module: seq_game_core

---
 rtl/seq_game_core.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_game_core.sv
// Memory-sequence game core: generates a random prompt sequence, shows it on
// one-hot lamps, then checks the player's channel entries against it.
module seq_game_core #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               go_i,
  input  logic [15:0]        seed_i,
  input  logic [NUM_CH-1:0]  ch_in_i,
  output logic [NUM_CH-1:0]  prompt_o,
  output logic               busy_o,
  output logic [6:0]         level_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [3:0]         lives_o,
  output logic               hit_o,
  output logic               miss_o,
  output logic               game_over_o,
  output logic               won_o
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int unsigned LVL_W  = 7;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, JUDGE, LOST, WON
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LVL_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               go_q;
  logic [NUM_CH-1:0]  ch_q;
  logic [CH_W-1:0]    seq_q [MAX_LEN];

  logic [NUM_CH-1:0]  prompt_q, prompt_d;
  logic               busy_q, busy_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               over_q, over_d;
  logic               won_q, won_d;

  logic               go_rise;
  logic [NUM_CH-1:0]  ch_rise;
  logic               tick;
  logic [15:0]        lfsr_step;
  logic [NUM_CH-1:0]  exp_onehot;
  logic [LVL_W-1:0]   idx_inc;
  logic               hit_evt, miss_evt;
  logic               seq_we;
  logic [CH_W-1:0]    seq_wdata;
  logic [CH_W-1:0]    show_sym;

  assign go_rise    = go_i & ~go_q;
  assign ch_rise    = ch_in_i & ~ch_q;
  assign tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign lfsr_step  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign exp_onehot = NUM_CH'(1) << seq_q[idx_q[IDX_W-1:0]];
  assign idx_inc    = idx_q + LVL_W'(1);
  assign seq_wdata  = lfsr_step[CH_W-1:0];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    level_d  = level_q;
    idx_d    = idx_q;
    score_d  = score_q;
    lives_d  = lives_q;
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    to_d     = to_q;
    hit_evt  = 1'b0;
    miss_evt = 1'b0;
    seq_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (go_rise) begin
          lfsr_d  = (seed_i == 16'h0000) ? LFSR_INIT : seed_i;
          level_d = '0;
          score_d = '0;
          lives_d = 4'(START_LIVES);
          state_d = GEN;
        end
      end
      GEN: begin
        lfsr_d  = lfsr_step;
        seq_we  = 1'b1;
        level_d = level_q + LVL_W'(1);
        idx_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (tick) state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (tick) begin
          if (idx_inc < level_q) begin
            idx_d   = idx_inc;
            state_d = SHOW_ON;
          end else begin
            idx_d   = '0;
            state_d = INPUT;
          end
        end
      end
      INPUT: begin
        if (tick) to_d = to_q + TO_W'(1);
        if (|ch_rise) begin
          // Any entry restarts the inactivity window
          cnt_d = '0;
          to_d  = '0;
          if (ch_rise == exp_onehot) hit_evt  = 1'b1;
          else                       miss_evt = 1'b1;
        end else if (tick && (to_q == TO_W'(TIMEOUT_TICKS - 1))) begin
          miss_evt = 1'b1;
        end
        if (hit_evt) begin
          idx_d = idx_inc;
          if (idx_inc == level_q) begin
            score_d = (&score_q) ? score_q : score_q + SCORE_W'(1);
            state_d = JUDGE;
          end
        end
        if (miss_evt) begin
          lives_d = lives_q - 4'd1;
          idx_d   = '0;
          state_d = (lives_q == 4'd1) ? LOST : SHOW_ON;
        end
      end
      JUDGE: begin
        state_d = (level_q == LVL_W'(MAX_LEN)) ? WON : GEN;
      end
      LOST, WON: begin
        if (go_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Tick and timeout counters restart whenever a timed state is entered
    if ((state_d != state_q) && (state_d inside {SHOW_ON, SHOW_OFF, INPUT})) begin
      cnt_d = '0;
      to_d  = '0;
    end
  end

  // Output decode from the next state so registered outputs align with the state
  always_comb begin
    prompt_d = '0;
    busy_d   = 1'b0;
    over_d   = 1'b0;
    won_d    = 1'b0;
    hit_d    = hit_evt;
    miss_d   = miss_evt;
    // Forward the element being written so the first lamp is not stale
    show_sym = (seq_we && (idx_d[IDX_W-1:0] == level_q[IDX_W-1:0])) ? seq_wdata
                                                                    : seq_q[idx_d[IDX_W-1:0]];
    case (state_d)
      SHOW_ON: begin
        prompt_d = NUM_CH'(1) << show_sym;
        busy_d   = 1'b1;
      end
      SHOW_OFF: busy_d = 1'b1;
      LOST:     over_d = 1'b1;
      WON: begin
        over_d = 1'b1;
        won_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q   <= LFSR_INIT;
      level_q  <= '0;
      idx_q    <= '0;
      score_q  <= '0;
      lives_q  <= 4'(START_LIVES);
      cnt_q    <= '0;
      to_q     <= '0;
      go_q     <= 1'b1;
      ch_q     <= '0;
      prompt_q <= '0;
      busy_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      level_q  <= level_d;
      idx_q    <= idx_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      go_q     <= go_i;
      ch_q     <= ch_in_i;
      prompt_q <= prompt_d;
      busy_q   <= busy_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      over_q   <= over_d;
      won_q    <= won_d;
    end
  end

  // Sequence memory, contents need no reset
  always_ff @(posedge clk_i) begin
    if (seq_we) seq_q[level_q[IDX_W-1:0]] <= seq_wdata;
  end

  assign prompt_o    = prompt_q;
  assign busy_o      = busy_q;
  assign level_o     = level_q;
  assign score_o     = score_q;
  assign lives_o     = lives_q;
  assign hit_o       = hit_q;
  assign miss_o      = miss_q;
  assign game_over_o = over_q;
  assign won_o       = won_q;

endmodule
